gcd_engine_param: RTL

//   Parametrised, self-contained GCD engine: subtraction datapath plus its controlling FSM in one block.

---
 rtl/gcd_engine_param.sv | 87 ++++++++
 1 files changed

// File: rtl/gcd_engine_param.sv
// Subtraction-based GCD engine with operand and result valid/ready handshakes.
// One operation in flight; iteration counter saturates at all-ones.
module gcd_engine_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // a|b yields the answer for equal operands and any zero operand
        if (a_q == b_q || a_q == '0 || b_q == '0) begin
          gcd_d   = a_q | b_q;
          state_d = DONE;
        end else begin
          if (a_q > b_q) a_d = a_q - b_q;
          else           b_d = b_q - a_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign gcd_out   = gcd_q;
  assign iter_cnt  = cnt_q;

endmodule
